wb_inst_sequencer: RTL and testbench

- Wishbone slave-side controller that feeds queued instruction words to the core's 128-bit instruction/data bus.
- Captures store traffic from the core.
- Replaces the bench's hand-driven i_wb_dat/i_wb_ack stimulus with a proper FIFO-backed responder.
- Sits between the stimulus layer (push side) and the core's wishbone master port.

---
 rtl/wb_inst_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_wb_inst_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_inst_sequencer.sv
`timescale 1ns/1ps
// wb_inst_sequencer
//   Wishbone slave-side responder for a core's 128-bit instruction/data bus.
//   Instruction words are queued from a stimulus push port and returned on
//   reads in the 32-bit lane selected by adr[3:2]. The other lanes carry
//   FILL_WORD. Stores are captured and reported on a one-cycle o_wr_* strobe.
//
// Parameters
//   DEPTH     instruction FIFO entries (power of 2, >= 2)
//   ACK_WAIT  wait-state cycles inserted before each ack/err (0..15)
//   FILL_WORD NOP word used for unused lanes and empty-FIFO reads
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_push, i_push_inst     enqueue an instruction word
//   o_full/o_empty/o_count  FIFO status
//   i_wb_*                  core wishbone master signals (adr/sel/we/cyc/stb/wdat)
//   o_wb_dat/ack/err        wishbone response
//   o_wr_valid/adr/sel/dat  captured store, one-cycle pulse
//   o_fetch_cnt             number of acked reads (wraps)
//
// Optional feature (macro WB_SEQ_OVF_FLAG_EN)
//   Adds o_overflow: sticky flag set after a push is dropped on a full FIFO,
//   cleared only by reset.
module wb_inst_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ACK_WAIT  = 0,
  parameter logic [31:0] FILL_WORD = 32'hF0801003
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [31:0]                i_push_inst,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic [31:0]                i_wb_adr,
  input  logic [15:0]                i_wb_sel,
  input  logic                       i_wb_we,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  output logic [127:0]               o_wb_dat,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic                       o_wr_valid,
  output logic [31:0]                o_wr_adr,
  output logic [15:0]                o_wr_sel,
  output logic [127:0]               o_wr_dat,
  input  logic [127:0]               i_wb_wdat,
  output logic [15:0]                o_fetch_cnt
`ifdef WB_SEQ_OVF_FLAG_EN
  ,
  output logic                       o_overflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     wait_cnt;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic           lat_we;
  logic [31:0]    lat_adr;
  logic [15:0]    lat_sel;
  logic [127:0]   lat_wdat;

  logic           req;
  logic           req_we;
  logic [31:0]    req_adr;
  logic [15:0]    req_sel;
  logic [127:0]   req_wdat;
  logic           fire;
  logic           pop;
  logic           push_ok;
  logic [127:0]   rd_data;

  assign o_count = count;
  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);

  // With no wait states the response is produced straight from IDLE, so the
  // request must come from the live bus rather than the latch.
  always_comb begin
    req      = i_wb_cyc & i_wb_stb;
    req_we   = (state == IDLE) ? i_wb_we   : lat_we;
    req_adr  = (state == IDLE) ? i_wb_adr  : lat_adr;
    req_sel  = (state == IDLE) ? i_wb_sel  : lat_sel;
    req_wdat = (state == IDLE) ? i_wb_wdat : lat_wdat;

    fire = 1'b0;
    if (state == IDLE && req && ACK_WAIT == 0)
      fire = 1'b1;
    else if (state == WAIT && req && wait_cnt == 4'd1)
      fire = 1'b1;

    // Head is chosen from pre-edge occupancy: a same-edge push into an empty
    // FIFO is not visible to this read.
    pop     = fire & ~req_we & ~o_empty;
    push_ok = i_push & (~o_full | pop);

    rd_data = {4{FILL_WORD}};
    if (!o_empty)
      rd_data[{req_adr[3:2], 5'd0} +: 32] = mem[rd_ptr];
  end

  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem[wr_ptr] <= i_push_inst;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_adr     <= '0;
      lat_sel     <= '0;
      lat_wdat    <= '0;
      o_wb_dat    <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_wr_adr    <= '0;
      o_wr_sel    <= '0;
      o_wr_dat    <= '0;
      o_fetch_cnt <= '0;
    end else begin
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            lat_we   <= i_wb_we;
            lat_adr  <= i_wb_adr;
            lat_sel  <= i_wb_sel;
            lat_wdat <= i_wb_wdat;
            wait_cnt <= 4'(ACK_WAIT);
            state    <= (ACK_WAIT == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1)
              state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fire) begin
        if (!req_we) begin
          o_wb_ack    <= 1'b1;
          o_wb_dat    <= rd_data;
          o_fetch_cnt <= o_fetch_cnt + 16'd1;
        end else if (req_sel != '0) begin
          o_wb_ack   <= 1'b1;
          o_wr_valid <= 1'b1;
          o_wr_adr   <= req_adr;
          o_wr_sel   <= req_sel;
          o_wr_dat   <= req_wdat;
        end else begin
          o_wb_err <= 1'b1;
        end
      end
    end
  end

`ifdef WB_SEQ_OVF_FLAG_EN
  logic drop;
  assign drop = i_push & o_full & ~pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_overflow <= 1'b0;
    else if (drop)
      o_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb_inst_sequencer.sv
`timescale 1ns/1ps
// tb_wb_inst_sequencer
//   Drives two sequencer instances (ACK_WAIT = 0 and ACK_WAIT = 3) from one
//   shared stimulus stream and checks both against a transaction-level model
//   built on queues, plus literal expectations at fixed points.
module tb_wb_inst_sequencer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] FILL  = 32'hF0801003;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         push  = 1'b0;
  logic [31:0]  inst  = '0;
  logic         cyc   = 1'b0;
  logic         stb   = 1'b0;
  logic         we    = 1'b0;
  logic [31:0]  adr   = '0;
  logic [15:0]  sel   = '0;
  logic [127:0] wdat  = '0;

  logic         d_full  [2];
  logic         d_empty [2];
  logic [3:0]   d_count [2];
  logic [127:0] d_dat   [2];
  logic         d_ack   [2];
  logic         d_err   [2];
  logic         d_wrv   [2];
  logic [31:0]  d_wadr  [2];
  logic [15:0]  d_wsel  [2];
  logic [127:0] d_wdat  [2];
  logic [15:0]  d_fetch [2];
`ifdef WB_SEQ_OVF_FLAG_EN
  logic         d_ovf   [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int hold   = 0;

  always #5 clk = ~clk;

  wb_inst_sequencer #(.DEPTH(DEPTH), .ACK_WAIT(0), .FILL_WORD(FILL)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_push_inst(inst),
    .o_full(d_full[0]), .o_empty(d_empty[0]), .o_count(d_count[0]),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_dat(d_dat[0]), .o_wb_ack(d_ack[0]), .o_wb_err(d_err[0]),
    .o_wr_valid(d_wrv[0]), .o_wr_adr(d_wadr[0]), .o_wr_sel(d_wsel[0]),
    .o_wr_dat(d_wdat[0]), .i_wb_wdat(wdat), .o_fetch_cnt(d_fetch[0])
`ifdef WB_SEQ_OVF_FLAG_EN
    , .o_overflow(d_ovf[0])
`endif
  );

  wb_inst_sequencer #(.DEPTH(DEPTH), .ACK_WAIT(3), .FILL_WORD(FILL)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_push_inst(inst),
    .o_full(d_full[1]), .o_empty(d_empty[1]), .o_count(d_count[1]),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_dat(d_dat[1]), .o_wb_ack(d_ack[1]), .o_wb_err(d_err[1]),
    .o_wr_valid(d_wrv[1]), .o_wr_adr(d_wadr[1]), .o_wr_sel(d_wsel[1]),
    .o_wr_dat(d_wdat[1]), .i_wb_wdat(wdat), .o_fetch_cnt(d_fetch[1])
`ifdef WB_SEQ_OVF_FLAG_EN
    , .o_overflow(d_ovf[1])
`endif
  );

  // ---------------- reference model ----------------
  logic [31:0]  q0 [$];
  logic [31:0]  q1 [$];
  int           rem    [2];
  bit           resp   [2];
  logic         l_we   [2];
  logic [31:0]  l_adr  [2];
  logic [15:0]  l_sel  [2];
  logic [127:0] l_wdat [2];
  logic         e_ack  [2];
  logic         e_err  [2];
  logic         e_wrv  [2];
  logic [127:0] e_dat  [2];
  logic [31:0]  e_wadr [2];
  logic [15:0]  e_wsel [2];
  logic [127:0] e_wdat [2];
  logic [15:0]  e_fetch[2];
  logic         e_ovf  [2];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input logic [31:0] w);
    if (d == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic qpop(input int d, output logic [31:0] w);
    if (d == 0) w = q0.pop_front();
    else        w = q1.pop_front();
  endtask

  task automatic mreset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      rem[d] = 0; resp[d] = 0;
      l_we[d] = 0; l_adr[d] = '0; l_sel[d] = '0; l_wdat[d] = '0;
      e_ack[d] = 0; e_err[d] = 0; e_wrv[d] = 0; e_dat[d] = '0;
      e_wadr[d] = '0; e_wsel[d] = '0; e_wdat[d] = '0; e_fetch[d] = '0; e_ovf[d] = 0;
    end
  endtask

  task automatic respond(input int d);
    logic [127:0] v;
    logic [31:0]  w;
    resp[d] = 1;
    if (!l_we[d]) begin
      v = {4{FILL}};
      if (qsize(d) > 0) begin
        qpop(d, w);
        v[32*int'(l_adr[d][3:2]) +: 32] = w;
      end
      e_dat[d]   = v;
      e_ack[d]   = 1;
      e_fetch[d] = e_fetch[d] + 16'd1;
    end else if (l_sel[d] != '0) begin
      e_ack[d]  = 1;
      e_wrv[d]  = 1;
      e_wadr[d] = l_adr[d];
      e_wsel[d] = l_sel[d];
      e_wdat[d] = l_wdat[d];
    end else begin
      e_err[d] = 1;
    end
  endtask

  // One clock of the bus/queue rules for instance d: a request seen while
  // idle waits wait_of(d) cycles (aborting if cyc/stb drop), then responds;
  // the response cycle itself ignores the bus. Pops precede pushes.
  task automatic model_step(input int d);
    bit go;
    go = 0;
    e_ack[d] = 0; e_err[d] = 0; e_wrv[d] = 0;
    if (resp[d]) begin
      resp[d] = 0;
    end else if (rem[d] > 0) begin
      if (!(cyc && stb)) rem[d] = 0;
      else begin
        rem[d]--;
        if (rem[d] == 0) go = 1;
      end
    end else if (cyc && stb) begin
      l_we[d] = we; l_adr[d] = adr; l_sel[d] = sel; l_wdat[d] = wdat;
      if (wait_of(d) == 0) go = 1;
      else rem[d] = wait_of(d);
    end
    if (go) respond(d);
    if (push) begin
      if (qsize(d) < DEPTH) qpush(d, inst);
      else e_ovf[d] = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_ack", d),   128'(d_ack[d]),   128'(e_ack[d]));
      chk($sformatf("d%0d_err", d),   128'(d_err[d]),   128'(e_err[d]));
      chk($sformatf("d%0d_wrv", d),   128'(d_wrv[d]),   128'(e_wrv[d]));
      chk($sformatf("d%0d_dat", d),   d_dat[d],         e_dat[d]);
      chk($sformatf("d%0d_wadr", d),  128'(d_wadr[d]),  128'(e_wadr[d]));
      chk($sformatf("d%0d_wsel", d),  128'(d_wsel[d]),  128'(e_wsel[d]));
      chk($sformatf("d%0d_wdat", d),  d_wdat[d],        e_wdat[d]);
      chk($sformatf("d%0d_fetch", d), 128'(d_fetch[d]), 128'(e_fetch[d]));
      chk($sformatf("d%0d_count", d), 128'(d_count[d]), 128'(qsize(d)));
      chk($sformatf("d%0d_full", d),  128'(d_full[d]),  128'(qsize(d) == DEPTH));
      chk($sformatf("d%0d_empty", d), 128'(d_empty[d]), 128'(qsize(d) == 0));
      chk($sformatf("d%0d_ackerr", d), 128'(d_ack[d] & d_err[d]), 128'(0));
`ifdef WB_SEQ_OVF_FLAG_EN
      chk($sformatf("d%0d_ovf", d),   128'(d_ovf[d]),   128'(e_ovf[d]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic c, input logic w, input logic [31:0] a,
                     input logic [15:0] s, input logic [127:0] dd);
    cyc = c; stb = c; we = w; adr = a; sel = s; wdat = dd;
  endtask

  task automatic idle_bus();
    bus(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic push_word(input logic [31:0] w);
    push = 1'b1; inst = w;
    tick(1);
    push = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    push = 1'b0;
    idle_bus();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_empty", 128'(d_empty[0]), 128'(1));
    chk("rst_count", 128'(d_count[0]), 128'(0));
    chk("rst_ack",   128'(d_ack[0]),   128'(0));
    rst_n = 1'b1;
    tick(1);

    // single read at lane 0, no wait states
    push_word(32'hE3A01005);
    bus(1'b1, 1'b0, 32'h0, '0, '0);
    tick(1);
    chk("t1_ack",   128'(d_ack[0]),   128'(1));
    chk("t1_dat",   d_dat[0],         {FILL, FILL, FILL, 32'hE3A01005});
    chk("t1_empty", 128'(d_empty[0]), 128'(1));
    chk("t1_fetch", 128'(d_fetch[0]), 128'(1));
    idle_bus();
    tick(1);
    chk("t1_ack_drop", 128'(d_ack[0]), 128'(0));

    // FIFO order and lane placement
    push_word(32'hAAAA0001);
    push_word(32'hBBBB0002);
    chk("t2_count2", 128'(d_count[0]), 128'(2));
    bus(1'b1, 1'b0, 32'h8, '0, '0);
    tick(1);
    chk("t2_laneA", 128'(d_dat[0][95:64]), 128'(32'hAAAA0001));
    chk("t2_count1", 128'(d_count[0]), 128'(1));
    idle_bus();
    tick(1);
    bus(1'b1, 1'b0, 32'h4, '0, '0);
    tick(1);
    chk("t2_laneB", 128'(d_dat[0][63:32]), 128'(32'hBBBB0002));
    chk("t2_count0", 128'(d_count[0]), 128'(0));
    idle_bus();
    tick(1);

    // empty read, write capture, zero-select write
    bus(1'b1, 1'b0, 32'hC, '0, '0);
    tick(1);
    chk("t3_empty_dat", d_dat[0], {4{FILL}});
    chk("t3_empty_ack", 128'(d_ack[0]), 128'(1));
    idle_bus();
    tick(1);
    bus(1'b1, 1'b1, 32'h100, 16'h000F, 128'h1234);
    tick(1);
    chk("t3_wrv",  128'(d_wrv[0]),  128'(1));
    chk("t3_wadr", 128'(d_wadr[0]), 128'(32'h100));
    chk("t3_wsel", 128'(d_wsel[0]), 128'(16'h000F));
    chk("t3_wdat", d_wdat[0],       128'h1234);
    chk("t3_wdat_hold", d_dat[0],   {4{FILL}});
    idle_bus();
    tick(1);
    bus(1'b1, 1'b1, 32'h200, 16'h0000, 128'h55);
    tick(1);
    chk("t3_err",     128'(d_err[0]), 128'(1));
    chk("t3_err_ack", 128'(d_ack[0]), 128'(0));
    chk("t3_err_wrv", 128'(d_wrv[0]), 128'(0));
    idle_bus();
    tick(1);

    // wait states: abort, then full hold
    do_reset();
    push_word(32'hC0DE0001);
    push_word(32'hC0DE0002);
    bus(1'b1, 1'b0, 32'h0, '0, '0);
    tick(1);
    chk("t4_abort_ack1", 128'(d_ack[1]), 128'(0));
    tick(1);
    chk("t4_abort_ack2", 128'(d_ack[1]), 128'(0));
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t4_abort_noack", 128'(d_ack[1]), 128'(0));
    end
    chk("t4_abort_count", 128'(d_count[1]), 128'(2));
    bus(1'b1, 1'b0, 32'h0, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("t4_hold_ack", 128'(d_ack[1]), 128'(i == 4));
    end
    chk("t4_hold_dat", d_dat[1], {FILL, FILL, FILL, 32'hC0DE0001});
    idle_bus();
    tick(2);

    // overflow and push-while-full with a pop
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      push = 1'b1; inst = 32'hA0000000 + 32'(i);
      tick(1);
    end
    push = 1'b0;
    chk("t5_count", 128'(d_count[0]), 128'(DEPTH));
    chk("t5_full",  128'(d_full[0]),  128'(1));
`ifdef WB_SEQ_OVF_FLAG_EN
    chk("t5_ovf",   128'(d_ovf[0]),   128'(1));
`endif
    push = 1'b1; inst = 32'hDEADBEEF;
    bus(1'b1, 1'b0, 32'h0, '0, '0);
    tick(1);
    push = 1'b0;
    idle_bus();
    chk("t5_pp_count", 128'(d_count[0]), 128'(DEPTH));
    chk("t5_pp_head",  128'(d_dat[0][31:0]), 128'(32'hA0000000));
    tick(2);

    // asynchronous reset while ack is high
    do_reset();
    push_word(32'h11112222);
    bus(1'b1, 1'b0, 32'h0, '0, '0);
    @(posedge clk);
    #1 chk("t6_ack_before", 128'(d_ack[0]), 128'(1));
    #1 rst_n = 1'b0;
    idle_bus();
    #1;
    chk("t6_ack_async", 128'(d_ack[0]),   128'(0));
    chk("t6_count",     128'(d_count[0]), 128'(0));
    chk("t6_fetch",     128'(d_fetch[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // randomized traffic, model-checked every cycle
    do_reset();
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      push = ($urandom_range(0, 99) < ((k < 1500) ? 70 : 30));
      inst = $urandom();
      if (hold > 0) begin
        hold--;
      end else if (stb) begin
        idle_bus();
      end else if ($urandom_range(0, 9) < 4) begin
        hold = $urandom_range(0, 5);
        bus(1'b1, 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom()),
            {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      tick(1);
    end
    push = 1'b0;
    idle_bus();
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
